// File: rtl/bcd_digits_to_sign_8bits.sv
// Sign + three BCD digits to 8-bit two's complement, via multi-cycle shift-add accumulation.
// Latency: out_valid rises on the 4th rising edge after the accepting edge; one conversion per 6 cycles at best.
// Backpressure: in_ready only in IDLE; the result is held in OUT until out_ready is seen high on a clock edge.
// Build option: define BCD2BIN_SATURATE_EN to saturate on overflow (7F/80) instead of flagging err with a zero result.
module bcd_digits_to_sign_8bits (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       sign,
  input  logic [3:0] hundreds,
  input  logic [3:0] tens,
  input  logic [3:0] units,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] result,
  output logic       err,
  output logic       ovf
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ACC_H = 3'd1,
    ACC_T = 3'd2,
    ACC_U = 3'd3,
    FIN   = 3'd4,
    OUT   = 3'd5
  } state_t;

  state_t     state_q, state_d;

  logic       sign_q, sign_d;
  logic [3:0] hund_q, hund_d;
  logic [3:0] tens_q, tens_d;
  logic [3:0] units_q, units_d;
  logic [9:0] acc_q, acc_d;
  logic [7:0] result_q, result_d;
  logic       err_q, err_d;
  logic       ovf_q, ovf_d;
  logic       out_valid_q, out_valid_d;

  // Shift-add partial products; 10 bits hold 999 without wrapping.
  logic [9:0] hund_x100;
  logic [9:0] tens_x10;
  logic [9:0] units_ext;

  // Values registered when leaving FIN.
  logic       digit_bad;
  logic       range_ovf;
  logic [7:0] neg_mag;
  logic [7:0] fin_result;
  logic       fin_err;
  logic       fin_ovf;

  // x100 = x<<6 + x<<5 + x<<2 ; x10 = x<<3 + x<<1 (no multiplier).
  // Out-of-range digits may wrap the sum, but they are reported as err anyway.
  assign hund_x100 = {hund_q, 6'b0} + {1'b0, hund_q, 5'b0} + {4'b0, hund_q, 2'b0};
  assign tens_x10  = {2'b0, tens_q, 3'b0} + {5'b0, tens_q, 1'b0};
  assign units_ext = {6'b0, units_q};

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign err       = err_q;
  assign ovf       = ovf_q;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: fixed walk through the accumulate steps, handshake at both ends.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = ACC_H;
      ACC_H:   state_d = ACC_T;
      ACC_T:   state_d = ACC_U;
      ACC_U:   state_d = FIN;
      FIN:     state_d = OUT;
      OUT:     if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Final classification: bad digit beats range overflow; negative range reaches 128.
  always_comb begin
    digit_bad = (hund_q > 4'd9) || (tens_q > 4'd9) || (units_q > 4'd9);
    range_ovf = sign_q ? (acc_q > 10'd128) : (acc_q > 10'd127);
    neg_mag   = 8'd0 - acc_q[7:0];
    fin_result = sign_q ? neg_mag : acc_q[7:0];
    fin_err    = 1'b0;
    fin_ovf    = 1'b0;
    if (digit_bad) begin
      fin_result = 8'h00;
      fin_err    = 1'b1;
    end else if (range_ovf) begin
      fin_ovf = 1'b1;
`ifdef BCD2BIN_SATURATE_EN
      fin_result = sign_q ? 8'h80 : 8'h7F;
`else
      fin_result = 8'h00;
      fin_err    = 1'b1;
`endif
    end
  end

  // Datapath next-state: latch operands on accept, accumulate, publish in FIN, retire in OUT.
  always_comb begin
    sign_d      = sign_q;
    hund_d      = hund_q;
    tens_d      = tens_q;
    units_d     = units_q;
    acc_d       = acc_q;
    result_d    = result_q;
    err_d       = err_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          sign_d  = sign;
          hund_d  = hundreds;
          tens_d  = tens;
          units_d = units;
          acc_d   = 10'd0;
        end
      end
      ACC_H: acc_d = hund_x100;
      ACC_T: acc_d = acc_q + tens_x10;
      ACC_U: acc_d = acc_q + units_ext;
      FIN: begin
        result_d    = fin_result;
        err_d       = fin_err;
        ovf_d       = fin_ovf;
        out_valid_d = 1'b1;
      end
      OUT: begin
        if (out_ready) out_valid_d = 1'b0;
      end
      default: out_valid_d = 1'b0;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sign_q      <= 1'b0;
      hund_q      <= 4'd0;
      tens_q      <= 4'd0;
      units_q     <= 4'd0;
      acc_q       <= 10'd0;
      result_q    <= 8'h00;
      err_q       <= 1'b0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      sign_q      <= sign_d;
      hund_q      <= hund_d;
      tens_q      <= tens_d;
      units_q     <= units_d;
      acc_q       <= acc_d;
      result_q    <= result_d;
      err_q       <= err_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_bcd_digits_to_sign_8bits.sv
// Bench for bcd_digits_to_sign_8bits: scenario tasks, scoreboard of expected outputs.
// Expected values come from a decimal-arithmetic model of the conversion.
// Inputs are driven at negedge or #1 after posedge; outputs are sampled #1 after posedge or at negedge.
module tb_bcd_digits_to_sign_8bits;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic       sign;
  logic [3:0] hundreds;
  logic [3:0] tens;
  logic [3:0] units;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] result;
  logic       err;
  logic       ovf;

  int n_checks = 0;
  int n_fail   = 0;

  // Scoreboard entries: {ovf, err, result}
  logic [9:0] sb[$];

  bcd_digits_to_sign_8bits dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sign      (sign),
    .hundreds  (hundreds),
    .tens      (tens),
    .units     (units),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .err       (err),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model using plain decimal arithmetic.
  function automatic logic [9:0] exp_of(input logic s, input logic [3:0] h, input logic [3:0] t, input logic [3:0] u);
    int         m;
    logic [7:0] r;
    logic       e;
    logic       o;
    r = 8'h00; e = 1'b0; o = 1'b0;
    if (h > 9 || t > 9 || u > 9) begin
      e = 1'b1;
    end else begin
      m = h * 100 + t * 10 + u;
      if ((!s && m > 127) || (s && m > 128)) begin
        o = 1'b1;
`ifdef BCD2BIN_SATURATE_EN
        r = s ? 8'h80 : 8'h7F;
`else
        e = 1'b1;
`endif
      end else begin
        r = s ? 8'((256 - m) % 256) : 8'(m);
      end
    end
    return {o, e, r};
  endfunction

  function automatic logic [9:0] sb_pop();
    if (sb.size() == 0) return 10'h3FF;
    return sb.pop_front();
  endfunction

  // Drive one conversion, push its expectation, return what the DUT showed and when.
  task automatic do_conv(input logic s, input logic [3:0] h, input logic [3:0] t, input logic [3:0] u,
                         output logic [9:0] got, output int lat, output logic rdy_after);
    int w;
    w = 0;
    @(negedge clk);
    while (!in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    sign = s; hundreds = h; tens = t; units = u; in_valid = 1'b1;
    @(posedge clk);
    sb.push_back(exp_of(s, h, t, u));
    #1 in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    got = {ovf, err, result};
    rdy_after = 1'b0;
    if (out_valid && out_ready) begin
      @(posedge clk);
      #1;
      rdy_after = in_ready;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    sign = 1'b0; hundreds = 4'd0; tens = 4'd0; units = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({in_ready, out_valid, result, err, ovf} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_outputs: got rdy=%b vld=%b res=%h err=%b ovf=%b, want rdy=1 vld=0 res=00 err=0 ovf=0",
               in_ready, out_valid, result, err, ovf);
    end
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic test_min_negative();
    logic [9:0] got, exp;
    int         lat;
    logic       ra;
    do_conv(1'b1, 4'd1, 4'd2, 4'd8, got, lat, ra);
    exp = sb_pop();
    n_checks++;
    if (got !== exp || exp !== 10'h080) begin
      n_fail++;
      $display("FAIL min_negative: got %h, want %h", got, exp);
    end
    n_checks++;
    if (lat !== 4) begin
      n_fail++;
      $display("FAIL latency: out_valid after %0d edges, want 4", lat);
    end
    n_checks++;
    if (ra !== 1'b1) begin
      n_fail++;
      $display("FAIL ready_after_handshake: in_ready=%b, want 1", ra);
    end
  endtask

  task automatic test_range_edges();
    logic [9:0] got, exp;
    int         lat;
    logic       ra;
    logic [12:0] vec[3];
    vec[0] = {1'b0, 4'd1, 4'd2, 4'd7};
    vec[1] = {1'b0, 4'd0, 4'd0, 4'd0};
    vec[2] = {1'b1, 4'd0, 4'd0, 4'd0};
    for (int i = 0; i < 3; i++) begin
      do_conv(vec[i][12], vec[i][11:8], vec[i][7:4], vec[i][3:0], got, lat, ra);
      exp = sb_pop();
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL range_edge_%0d: got %h, want %h", i, got, exp);
      end
    end
  endtask

  task automatic test_overflow();
    logic [9:0] got, exp;
    int         lat;
    logic       ra;
    do_conv(1'b0, 4'd2, 4'd5, 4'd5, got, lat, ra);
    exp = sb_pop();
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL overflow_pos: got %h, want %h", got, exp);
    end
    do_conv(1'b1, 4'd1, 4'd2, 4'd9, got, lat, ra);
    exp = sb_pop();
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL overflow_neg: got %h, want %h", got, exp);
    end
    do_conv(1'b1, 4'd9, 4'd9, 4'd9, got, lat, ra);
    exp = sb_pop();
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL overflow_999: got %h, want %h", got, exp);
    end
  endtask

  task automatic test_bad_digit();
    logic [9:0] got, exp;
    int         lat;
    logic       ra;
    do_conv(1'b0, 4'd0, 4'd10, 4'd3, got, lat, ra);
    exp = sb_pop();
    n_checks++;
    if (got !== exp || exp !== 10'h100) begin
      n_fail++;
      $display("FAIL bad_digit_tens: got %h, want %h", got, exp);
    end
    do_conv(1'b1, 4'd15, 4'd0, 4'd0, got, lat, ra);
    exp = sb_pop();
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL bad_digit_hund: got %h, want %h", got, exp);
    end
  endtask

  task automatic test_backpressure();
    logic [9:0] exp;
    int         lat;
    int         bad;
    out_ready = 1'b0;
    @(negedge clk);
    sign = 1'b0; hundreds = 4'd0; tens = 4'd4; units = 4'd2; in_valid = 1'b1;
    @(posedge clk);
    sb.push_back(exp_of(1'b0, 4'd0, 4'd4, 4'd2));
    // Second operand set held on the bus for the whole wait.
    #1 sign = 1'b1; hundreds = 4'd0; tens = 4'd0; units = 4'd5;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    exp = sb_pop();
    bad = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_checks++;
      if (!(out_valid === 1'b1 && in_ready === 1'b0 && {ovf, err, result} === exp)) begin
        n_fail++; bad++;
        $display("FAIL hold_cycle_%0d: vld=%b rdy=%b out=%h, want vld=1 rdy=0 out=%h",
                 c, out_valid, in_ready, {ovf, err, result}, exp);
      end
    end
    n_checks++;
    if (exp !== 10'h02A) begin
      n_fail++;
      $display("FAIL hold_value: expected entry %h, want 02A", exp);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL handshake_release: rdy=%b vld=%b, want rdy=1 vld=0", in_ready, out_valid);
    end
    @(posedge clk);
    sb.push_back(exp_of(1'b1, 4'd0, 4'd0, 4'd5));
    #1 in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    exp = sb_pop();
    n_checks++;
    if ({ovf, err, result} !== exp || lat !== 4) begin
      n_fail++;
      $display("FAIL second_after_wait: got %h lat %0d, want %h lat 4", {ovf, err, result}, lat, exp);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid();
    logic [9:0] got, exp;
    int         lat;
    logic       ra;
    int         seen;
    @(negedge clk);
    sign = 1'b1; hundreds = 4'd0; tens = 4'd9; units = 4'd9; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk) rst_n = 1'b0;
    #1;
    n_checks++;
    if ({in_ready, out_valid, result, err, ovf} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_mid_outputs: got rdy=%b vld=%b res=%h err=%b ovf=%b, want 1 0 00 0 0",
               in_ready, out_valid, result, err, ovf);
    end
    @(negedge clk) rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    n_checks++;
    if (seen != 0) begin
      n_fail++;
      $display("FAIL reset_discard: out_valid seen %0d cycles, want 0", seen);
    end
    do_conv(1'b1, 4'd0, 4'd9, 4'd9, got, lat, ra);
    exp = sb_pop();
    n_checks++;
    if (got !== exp || exp !== 10'h09D || lat !== 4) begin
      n_fail++;
      $display("FAIL after_reset_conv: got %h lat %0d, want %h lat 4", got, lat, exp);
    end
  endtask

  task automatic test_back_to_back();
    logic [9:0] got, exp;
    int         lat;
    logic       ra;
    logic       s;
    logic [3:0] h, t, u;
    for (int i = 0; i < 12; i++) begin
      s = 1'($urandom_range(0, 1));
      h = 4'($urandom_range(0, 2));
      t = 4'($urandom_range(0, 11));
      u = 4'($urandom_range(0, 11));
      do_conv(s, h, t, u, got, lat, ra);
      exp = sb_pop();
      n_checks++;
      if (got !== exp || lat !== 4) begin
        n_fail++;
        $display("FAIL random_%0d s=%b d=%0d,%0d,%0d: got %h lat %0d, want %h lat 4", i, s, h, t, u, got, lat, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_min_negative();
    test_range_edges();
    test_overflow();
    test_bad_digit();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
